// File: rtl/qrs_frame_sequencer.sv
// qrs_frame_sequencer
// Cuts the incoming ECG sample stream into FRAME_LEN-sample frames. For each
// frame it feeds the QRS detector, waits for its done/address report, converts
// the frame-relative R-peak address to an absolute sample index, drops peaks
// that fall inside the refractory window, and emits the surviving peaks with
// their RR interval over a valid/ready handshake.
//
// Ports
//   clock_iht    in   1   system clock, rising edge
//   reset        in   1   asynchronous active-high reset
//   s_valid      in   1   input sample valid
//   s_ready      out  1   sequencer accepts a sample (FEED only)
//   s_data       in  16   ECG sample
//   X            out 16   sample forwarded to the detector
//   x_valid      out  1   X holds a new sample this cycle
//   det_start    out  1   one-cycle pulse at the start of every frame
//   det_done     in   1   detector finished the current frame
//   det_addr     in  32   frame-relative R-peak address, sampled with det_done
//   peak_valid   out  1   peak record available
//   peak_ready   in   1   consumer accepts the record
//   peak_addr    out 32   absolute sample index of the R peak
//   rr_interval  out 32   distance to the previous accepted peak (0 for first)
//   frame_count  out 16   completed frames, wraps
//   timeout_err  out  1   sticky: a frame timed out waiting for det_done
//   range_err    out  1   sticky: det_addr >= FRAME_LEN was reported
module qrs_frame_sequencer #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned REFRACT   = 50,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clock_iht,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic [15:0] X,
    output logic        x_valid,
    output logic        det_start,
    input  logic        det_done,
    input  logic [31:0] det_addr,
    output logic        peak_valid,
    input  logic        peak_ready,
    output logic [31:0] peak_addr,
    output logic [31:0] rr_interval,
    output logic [15:0] frame_count,
    output logic        timeout_err,
    output logic        range_err
);

    localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_FEED  = 2'd1,
        S_WAIT  = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [31:0]        frame_base_q, frame_base_d;
    logic [31:0]        last_peak_q, last_peak_d;
    logic               have_last_q, have_last_d;
    logic               s_ready_q, s_ready_d;
    logic [15:0]        x_q, x_d;
    logic               x_valid_q, x_valid_d;
    logic               det_start_q, det_start_d;
    logic               peak_valid_q, peak_valid_d;
    logic [31:0]        peak_addr_q, peak_addr_d;
    logic [31:0]        rr_q, rr_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               timeout_err_q, timeout_err_d;
    logic               range_err_q, range_err_d;

    logic               frame_close;
    logic [31:0]        abs_addr;
    logic [31:0]        delta;

    // Absolute peak index and its distance from the last accepted peak (32-bit wrap)
    assign abs_addr = frame_base_q + det_addr;
    assign delta    = abs_addr - last_peak_q;

    // State and output registers
    always_ff @(posedge clock_iht or posedge reset) begin
        if (reset) begin
            state_q       <= S_START;
            idx_q         <= '0;
            tmo_q         <= '0;
            frame_base_q  <= '0;
            last_peak_q   <= '0;
            have_last_q   <= 1'b0;
            s_ready_q     <= 1'b0;
            x_q           <= '0;
            x_valid_q     <= 1'b0;
            det_start_q   <= 1'b0;
            peak_valid_q  <= 1'b0;
            peak_addr_q   <= '0;
            rr_q          <= '0;
            frame_count_q <= '0;
            timeout_err_q <= 1'b0;
            range_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            frame_base_q  <= frame_base_d;
            last_peak_q   <= last_peak_d;
            have_last_q   <= have_last_d;
            s_ready_q     <= s_ready_d;
            x_q           <= x_d;
            x_valid_q     <= x_valid_d;
            det_start_q   <= det_start_d;
            peak_valid_q  <= peak_valid_d;
            peak_addr_q   <= peak_addr_d;
            rr_q          <= rr_d;
            frame_count_q <= frame_count_d;
            timeout_err_q <= timeout_err_d;
            range_err_q   <= range_err_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        frame_base_d  = frame_base_q;
        last_peak_d   = last_peak_q;
        have_last_d   = have_last_q;
        s_ready_d     = s_ready_q;
        x_d           = x_q;
        x_valid_d     = 1'b0;
        det_start_d   = 1'b0;
        peak_valid_d  = peak_valid_q;
        peak_addr_d   = peak_addr_q;
        rr_d          = rr_q;
        frame_count_d = frame_count_q;
        timeout_err_d = timeout_err_q;
        range_err_d   = range_err_q;
        frame_close   = 1'b0;

        case (state_q)
            S_START: begin
                det_start_d = 1'b1;
                idx_d       = '0;
                s_ready_d   = 1'b1;
                state_d     = S_FEED;
            end
            S_FEED: begin
                if (s_valid && s_ready_q) begin
                    x_d       = s_data;
                    x_valid_d = 1'b1;
                    idx_d     = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
                        s_ready_d = 1'b0;
                        state_d   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                // det_done takes priority over a simultaneous timeout expiry
                if (det_done) begin
                    if (det_addr >= 32'(FRAME_LEN)) begin
                        range_err_d = 1'b1;
                        frame_close = 1'b1;
                    end else if (have_last_q && (delta < 32'(REFRACT))) begin
                        frame_close = 1'b1;
                    end else begin
                        peak_addr_d  = abs_addr;
                        rr_d         = have_last_q ? delta : 32'd0;
                        last_peak_d  = abs_addr;
                        have_last_d  = 1'b1;
                        peak_valid_d = 1'b1;
                        state_d      = S_EMIT;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    frame_close   = 1'b1;
                end
            end
            S_EMIT: begin
                if (peak_ready) begin
                    peak_valid_d = 1'b0;
                    frame_close  = 1'b1;
                end
            end
            default: state_d = S_START;
        endcase

        // Common frame-close bookkeeping
        if (frame_close) begin
            frame_base_d  = frame_base_q + 32'(FRAME_LEN);
            frame_count_d = frame_count_q + 16'd1;
            tmo_d         = '0;
            state_d       = S_START;
        end
    end

    assign s_ready     = s_ready_q;
    assign X           = x_q;
    assign x_valid     = x_valid_q;
    assign det_start   = det_start_q;
    assign peak_valid  = peak_valid_q;
    assign peak_addr   = peak_addr_q;
    assign rr_interval = rr_q;
    assign frame_count = frame_count_q;
    assign timeout_err = timeout_err_q;
    assign range_err   = range_err_q;

endmodule

// File: tb/tb_qrs_frame_sequencer.sv
// tb_qrs_frame_sequencer
// Directed bench for qrs_frame_sequencer with FRAME_LEN=8, REFRACT=3,
// TIMEOUT=16. Expected values are hand-computed from the frame base
// (8 * frame number since reset) and the last accepted peak.
module tb_qrs_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic [15:0] x_out;
    logic        x_valid;
    logic        det_start;
    logic        det_done;
    logic [31:0] det_addr;
    logic        peak_valid;
    logic        peak_ready;
    logic [31:0] peak_addr;
    logic [31:0] rr_interval;
    logic [15:0] frame_count;
    logic        timeout_err;
    logic        range_err;

    int n_cmp = 0;
    int n_err = 0;

    qrs_frame_sequencer #(
        .FRAME_LEN(8),
        .REFRACT  (3),
        .TIMEOUT  (16)
    ) dut (
        .clock_iht  (clk),
        .reset      (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .X          (x_out),
        .x_valid    (x_valid),
        .det_start  (det_start),
        .det_done   (det_done),
        .det_addr   (det_addr),
        .peak_valid (peak_valid),
        .peak_ready (peak_ready),
        .peak_addr  (peak_addr),
        .rr_interval(rr_interval),
        .frame_count(frame_count),
        .timeout_err(timeout_err),
        .range_err  (range_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // det_start must appear exactly one cycle after reset release / frame close
    task automatic wait_start(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!det_start && n < 40);
        chk({tag, " start_latency"}, 32'(n), 32'd1);
    endtask

    // Stream n samples first..first+n-1 with s_valid held high
    task automatic feed(input string tag, input logic [15:0] first, input int n, input logic glitch);
        for (int i = 0; i < n; i++) begin
            chk({tag, " s_ready"}, 32'(s_ready), 32'd1);
            s_valid  = 1'b1;
            s_data   = first + 16'(i);
            det_done = glitch;
            det_addr = 32'd3;
            tick();
            chk({tag, " X"}, 32'(x_out), 32'(first + 16'(i)));
            chk({tag, " x_valid"}, 32'(x_valid), 32'd1);
        end
        s_valid  = 1'b0;
        det_done = 1'b0;
        det_addr = '0;
        if (n == 8) chk({tag, " s_ready_drop"}, 32'(s_ready), 32'd0);
    endtask

    task automatic do_done(input logic [31:0] addr);
        det_done = 1'b1;
        det_addr = addr;
        tick();
        det_done = 1'b0;
        det_addr = '0;
    endtask

    task automatic check_peak(input string tag, input logic [31:0] addr, input logic [31:0] rr);
        chk({tag, " peak_valid"}, 32'(peak_valid), 32'd1);
        chk({tag, " peak_addr"}, peak_addr, addr);
        chk({tag, " rr_interval"}, rr_interval, rr);
    endtask

    task automatic handshake(input string tag, input logic [15:0] fc);
        peak_ready = 1'b1;
        tick();
        peak_ready = 1'b0;
        chk({tag, " peak_valid_low"}, 32'(peak_valid), 32'd0);
        chk({tag, " frame_count"}, 32'(frame_count), 32'(fc));
    endtask

    initial begin
        rst        = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        det_done   = 1'b0;
        det_addr   = '0;
        peak_ready = 1'b0;
        repeat (3) tick();
        chk("rst flags", 32'({s_ready, x_valid, det_start, peak_valid, timeout_err, range_err}), 32'd0);
        chk("rst X", 32'(x_out), 32'd0);
        chk("rst peak_addr", peak_addr, 32'd0);
        chk("rst rr", rr_interval, 32'd0);
        chk("rst frame_count", 32'(frame_count), 32'd0);
        rst = 1'b0;

        // Basic frame: base 0, det_addr 5
        wait_start("f0");
        feed("f0", 16'd1, 8, 1'b0);
        do_done(32'd5);
        check_peak("f0", 32'd5, 32'd0);
        handshake("f0", 16'd1);

        // Back-pressure: base 8, det_addr 2 -> 10, rr 5
        wait_start("f1");
        feed("f1", 16'd9, 8, 1'b0);
        do_done(32'd2);
        for (int i = 0; i < 4; i++) begin
            check_peak("f1 hold", 32'd10, 32'd5);
            chk("f1 hold s_ready", 32'(s_ready), 32'd0);
            tick();
        end
        handshake("f1", 16'd2);

        // det_done on the timeout-expiry cycle wins: base 16 -> 16, rr 6
        wait_start("f2");
        feed("f2", 16'd17, 8, 1'b0);
        repeat (15) tick();
        do_done(32'd0);
        check_peak("f2", 32'd16, 32'd6);
        chk("f2 timeout_err", 32'(timeout_err), 32'd0);
        handshake("f2", 16'd3);

        // Range error: det_addr 8 at base 24
        wait_start("f3");
        feed("f3", 16'd25, 8, 1'b0);
        do_done(32'd8);
        chk("f3 peak_valid", 32'(peak_valid), 32'd0);
        chk("f3 range_err", 32'(range_err), 32'd1);
        chk("f3 frame_count", 32'(frame_count), 32'd4);

        // Timeout: 16 WAIT cycles without det_done at base 32
        wait_start("f4");
        feed("f4", 16'd33, 8, 1'b0);
        repeat (15) tick();
        chk("f4 timeout_err_early", 32'(timeout_err), 32'd0);
        tick();
        chk("f4 timeout_err", 32'(timeout_err), 32'd1);
        chk("f4 frame_count", 32'(frame_count), 32'd5);
        chk("f4 peak_valid", 32'(peak_valid), 32'd0);

        // det_done during FEED ignored; base 40, det_addr 1 -> 41, rr 25
        wait_start("f5");
        feed("f5", 16'd41, 8, 1'b1);
        do_done(32'd1);
        check_peak("f5", 32'd41, 32'd25);
        handshake("f5", 16'd6);

        // Reset after 4 samples: outputs clear asynchronously
        wait_start("f6");
        feed("f6", 16'd49, 4, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst flags", 32'({s_ready, x_valid, det_start, peak_valid, timeout_err, range_err}), 32'd0);
        chk("mid_rst X", 32'(x_out), 32'd0);
        chk("mid_rst peak_addr", peak_addr, 32'd0);
        chk("mid_rst rr", rr_interval, 32'd0);
        chk("mid_rst frame_count", 32'(frame_count), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // After reset: base 0 again, first peak rr 0
        wait_start("r0");
        feed("r0", 16'd1, 8, 1'b0);
        do_done(32'd7);
        check_peak("r0", 32'd7, 32'd0);
        handshake("r0", 16'd1);

        // Refractory: abs 9 is only 2 after 7 -> dropped
        wait_start("r1");
        feed("r1", 16'd9, 8, 1'b0);
        do_done(32'd1);
        chk("r1 peak_valid", 32'(peak_valid), 32'd0);
        chk("r1 frame_count", 32'(frame_count), 32'd2);

        // Next accepted peak measured from 7: abs 16, rr 9
        wait_start("r2");
        feed("r2", 16'd17, 8, 1'b0);
        do_done(32'd0);
        check_peak("r2", 32'd16, 32'd9);
        chk("r2 sticky_clear", 32'({timeout_err, range_err}), 32'd0);
        handshake("r2", 16'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
